tone_generator: RTL and testbench
=================================

TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the clk frequency in Hz used to derive note half-periods.
REQ-002 SHALL have parameter GAP_CYCLES, default 1_000_000, meaning the silent articulation gap between two consecutive different notes, in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: 1 = sound allowed; 0 = forced silence.
REQ-006 SHALL have port note_in, input, 4 bits: 0 = rest; 1..7 = do..si; 8..15 = rest.
REQ-007 SHALL have port octave_in, input, 2 bits: 0 = low, 1 = mid, 2 = high, 3 = treated as mid.
REQ-008 SHALL have port buzzer, output, 1 bit: square-wave drive to the speaker.
REQ-009 SHALL have port active, output, 1 bit: high while in the PLAY state.
REQ-010 SHALL have port note_cur, output, 4 bits: the note currently latched for playback (0 when none).

Function
REQ-011 SHALL register note_in, octave_in and enable each cycle; all decisions use the registered copies, giving 1 cycle of input latency.
REQ-012 SHALL use mid-octave frequencies 262, 294, 330, 349, 392, 440 and 494 Hz for notes 1..7.
REQ-013 SHALL set half-period H = CLK_HZ / (2*f), truncated, computed at elaboration.
REQ-014 SHALL use H<<1 for the low octave and H>>1 for the high octave.
REQ-015 SHALL use a 20-bit period counter; no overflow is allowed at the default CLK_HZ.
REQ-016 SHALL implement a state machine with states IDLE, PLAY and GAP.
REQ-017 IDLE: buzzer = 0, active = 0, note_cur = 0.
REQ-018 IDLE -> PLAY when enable = 1 and the note is in 1..7; SHALL latch note/octave, clear the counter and hold buzzer at 0.
REQ-019 PLAY: the counter increments each cycle; at H_eff-1 buzzer toggles and the counter clears, giving period 2*H_eff cycles at 50% duty.
REQ-020 PLAY, same note and octave held: SHALL continue with no phase disturbance.
REQ-021 PLAY -> GAP when the note changes to a different value in 1..7, or the octave changes; SHALL latch the new value, buzzer = 0, active = 0 and clear the gap counter.
REQ-022 GAP: buzzer = 0 for exactly GAP_CYCLES cycles, then -> PLAY with the counter cleared and buzzer starting at 0.
REQ-023 A further change during GAP SHALL re-latch the new value without restarting the gap counter.
REQ-024 A rest or enable = 0 in PLAY or GAP SHALL cause -> IDLE on the next edge, with buzzer = 0 that cycle.
REQ-025 Leaving rest into a note SHALL take the IDLE -> PLAY path with no gap.
REQ-026 note_cur SHALL equal the latched note in PLAY and GAP.
REQ-027 buzzer SHALL be driven directly from a flop, with no combinational glitches.

Reset
REQ-028 When reset = 0 at a clk edge: state = IDLE, buzzer = 0, active = 0, note_cur = 0, counters = 0 and input registers = 0.
REQ-029 Reset SHALL take effect mid-PLAY or mid-GAP; the next rising reset edge behaves as a fresh IDLE.

Verification (CLK_HZ = 100_000, GAP_CYCLES = 20)
REQ-030 Reset held 3 cycles during PLAY -> buzzer = 0, active = 0, note_cur = 0 on the first edge with reset = 0.
REQ-031 note_in = 6, octave = 1, enable = 1 -> active rises 2 cycles later; buzzer toggles every 113 cycles (period 226).
REQ-032 note 6 with octave 0 then octave 2 -> half-periods 226 and 56; the octave change inserts a 20-cycle gap with buzzer = 0.
REQ-033 In PLAY, note 6 -> 1 -> 20-cycle gap; note 3 applied at gap cycle 10 -> gap ends at cycle 20, then PLAY with note_cur = 3 and half-period 151.
REQ-034 In PLAY, note_in = 0 or enable = 0 -> IDLE, buzzer = 0 within 2 cycles; a following note 1 -> PLAY with no gap.
REQ-035 note_in = 9 or octave = 3 -> 9 is a rest (IDLE); octave 3 gives the same half-period as mid (note 1: 190).

Source files
------------

// File: rtl/tone_generator.sv
// Square-wave tone generator: plays do..si over three octaves, with a silent
// articulation gap inserted between consecutive different notes.
module tone_generator #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned GAP_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       buzzer,
  output logic       active,
  output logic [3:0] note_cur
);

  localparam int CNT_W = 20;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] H_DO = CNT_W'(CLK_HZ / (2 * 262));
  localparam logic [CNT_W-1:0] H_RE = CNT_W'(CLK_HZ / (2 * 294));
  localparam logic [CNT_W-1:0] H_MI = CNT_W'(CLK_HZ / (2 * 330));
  localparam logic [CNT_W-1:0] H_FA = CNT_W'(CLK_HZ / (2 * 349));
  localparam logic [CNT_W-1:0] H_SO = CNT_W'(CLK_HZ / (2 * 392));
  localparam logic [CNT_W-1:0] H_LA = CNT_W'(CLK_HZ / (2 * 440));
  localparam logic [CNT_W-1:0] H_SI = CNT_W'(CLK_HZ / (2 * 494));

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       note_in_q;
  logic [1:0]       oct_in_q;
  logic             en_q;
  logic [3:0]       note_q, note_d;
  logic [1:0]       oct_q, oct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             buz_q, buz_d;

  logic [CNT_W-1:0] h_base, h_eff;
  logic [1:0]       oct_norm;
  logic             in_valid, in_changed;

  always_comb begin
    case (note_q)
      4'd2:    h_base = H_RE;
      4'd3:    h_base = H_MI;
      4'd4:    h_base = H_FA;
      4'd5:    h_base = H_SO;
      4'd6:    h_base = H_LA;
      4'd7:    h_base = H_SI;
      default: h_base = H_DO;
    endcase
    case (oct_q)
      2'd0:    h_eff = h_base << 1;
      2'd2:    h_eff = h_base >> 1;
      default: h_eff = h_base;
    endcase
  end

  // Octave 3 is folded onto mid so that 1 <-> 3 is not seen as a change.
  assign oct_norm   = (oct_in_q == 2'd3) ? 2'd1 : oct_in_q;
  assign in_valid   = en_q && (note_in_q != 4'd0) && (note_in_q <= 4'd7);
  assign in_changed = (note_in_q != note_q) || (oct_norm != oct_q);

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    oct_d   = oct_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    buz_d   = buz_q;
    case (state_q)
      S_IDLE: begin
        buz_d  = 1'b0;
        cnt_d  = '0;
        gap_d  = '0;
        note_d = 4'd0;
        if (in_valid) begin
          state_d = S_PLAY;
          note_d  = note_in_q;
          oct_d   = oct_norm;
        end
      end
      S_PLAY: begin
        if (!in_valid) begin
          state_d = S_IDLE;
          buz_d   = 1'b0;
          cnt_d   = '0;
          note_d  = 4'd0;
        end else if (in_changed) begin
          state_d = S_GAP;
          note_d  = note_in_q;
          oct_d   = oct_norm;
          buz_d   = 1'b0;
          cnt_d   = '0;
          gap_d   = '0;
        end else if (cnt_q == h_eff - 1'b1) begin
          buz_d = ~buz_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        buz_d = 1'b0;
        if (!in_valid) begin
          state_d = S_IDLE;
          note_d  = 4'd0;
          gap_d   = '0;
        end else begin
          // Re-latch on every cycle; the gap timer keeps running regardless.
          note_d = note_in_q;
          oct_d  = oct_norm;
          if (gap_q == GAP_LAST) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      note_in_q <= 4'd0;
      oct_in_q  <= 2'd0;
      en_q      <= 1'b0;
      note_q    <= 4'd0;
      oct_q     <= 2'd0;
      cnt_q     <= '0;
      gap_q     <= '0;
      buz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_in_q <= note_in;
      oct_in_q  <= octave_in;
      en_q      <= enable;
      note_q    <= note_d;
      oct_q     <= oct_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      buz_q     <= buz_d;
    end
  end

  assign buzzer   = buz_q;
  assign active   = (state_q == S_PLAY);
  assign note_cur = note_q;

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: directed scenarios plus random note sequences,
// compared cycle by cycle with a phase-arithmetic reference model.
module tb_tone_generator;

  localparam int unsigned CLK_HZ = 100_000;
  localparam int unsigned GAP    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] note_in = 4'd0;
  logic [1:0] octave_in = 2'd0;
  logic       buzzer, active;
  logic [3:0] note_cur;

  int n_checks = 0;
  int n_fail   = 0;

  tone_generator #(.CLK_HZ(CLK_HZ), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .note_in(note_in),
    .octave_in(octave_in), .buzzer(buzzer), .active(active), .note_cur(note_cur)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 play, 2 gap; buzzer from elapsed time.
  int   cyc = 0, m_mode = 0, m_start = 0, m_gstart = 0, m_note = 0, m_oct = 0;
  int   r_note = 0, r_oct = 0;
  bit   r_en = 1'b0;
  bit   e_buz = 1'b0, e_act = 1'b0;
  logic [3:0] e_note = 4'd0;

  function automatic int ref_half(int n, int o);
    int f, h;
    case (n)
      1: f = 262; 2: f = 294; 3: f = 330; 4: f = 349;
      5: f = 392; 6: f = 440; default: f = 494;
    endcase
    h = int'(CLK_HZ) / (2 * f);
    if (o == 0) return h * 2;
    if (o == 2) return h / 2;
    return h;
  endfunction

  always @(posedge clk) begin : model
    bit valid;
    int no;
    cyc++;
    if (!reset) begin
      m_mode = 0; m_note = 0; m_oct = 0; r_note = 0; r_oct = 0; r_en = 1'b0;
    end else begin
      valid = r_en && r_note >= 1 && r_note <= 7;
      no = (r_oct == 3) ? 1 : r_oct;
      if (!valid) begin
        m_mode = 0; m_note = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_start = cyc; m_note = r_note; m_oct = no;
      end else if (m_mode == 1) begin
        if (r_note != m_note || no != m_oct) begin
          m_mode = 2; m_gstart = cyc; m_note = r_note; m_oct = no;
        end
      end else begin
        m_note = r_note; m_oct = no;
        if (cyc - m_gstart == int'(GAP)) begin m_mode = 1; m_start = cyc; end
      end
      r_note = int'(note_in); r_oct = int'(octave_in); r_en = enable;
    end
    e_act  = (m_mode == 1);
    e_buz  = (m_mode == 1) && (((cyc - m_start) / ref_half(m_note, m_oct)) % 2 == 1);
    e_note = 4'(m_note);
  end

  task automatic drive(input int n, input int o, input bit e);
    note_in = 4'(n); octave_in = 2'(o); enable = e;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(6, 1, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (buzzer !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
    n_checks++; if (note_cur !== 4'd0) begin n_fail++; $display("FAIL reset_note_cur: got %0d want 0", note_cur); end
    reset = 1'b1;
    drive(0, 1, 1'b1);
    repeat (3) begin
      @(negedge clk); n_checks++;
      if ({buzzer, active, note_cur} !== {e_buz, e_act, e_note}) begin
        n_fail++; $display("FAIL reset_idle: got buz=%b act=%b note=%0d want buz=%b act=%b note=%0d", buzzer, active, note_cur, e_buz, e_act, e_note);
      end
    end
  endtask

  task automatic test_basic_tone();
    int last, toggles;
    logic prev;
    drive(6, 1, 1'b1);
    @(negedge clk);
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: active=%b want 0", active); end
    @(negedge clk);
    n_checks++; if (active !== 1'b1 || note_cur !== 4'd6 || buzzer !== 1'b0) begin
      n_fail++; $display("FAIL basic_start: act=%b note=%0d buz=%b want 1 6 0", active, note_cur, buzzer);
    end
    last = 0; toggles = 0; prev = buzzer;
    for (int i = 1; i <= 600 && toggles < 4; i++) begin
      @(negedge clk); n_checks++;
      if ({buzzer, active, note_cur} !== {e_buz, e_act, e_note}) begin
        n_fail++; $display("FAIL basic_model: got buz=%b act=%b note=%0d want buz=%b act=%b note=%0d", buzzer, active, note_cur, e_buz, e_act, e_note);
      end
      if (buzzer !== prev) begin
        n_checks++;
        if (i - last != 113) begin n_fail++; $display("FAIL basic_half: got %0d want 113", i - last); end
        last = i; toggles++; prev = buzzer;
      end
    end
    n_checks++; if (toggles < 4) begin n_fail++; $display("FAIL basic_timeout: toggles %0d want 4", toggles); end
  endtask

  task automatic test_octave();
    int oct, want, gap, lo;
    bit buz_in_gap;
    for (int s = 0; s < 2; s++) begin
      oct  = (s == 0) ? 0 : 2;
      want = (s == 0) ? 226 : 56;
      drive(6, oct, 1'b1);
      gap = 0; buz_in_gap = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); n_checks++;
        if ({buzzer, active, note_cur} !== {e_buz, e_act, e_note}) begin
          n_fail++; $display("FAIL octave_model: got buz=%b act=%b note=%0d want buz=%b act=%b note=%0d", buzzer, active, note_cur, e_buz, e_act, e_note);
        end
        if (active === 1'b0) begin gap++; if (buzzer !== 1'b0) buz_in_gap = 1'b1; end
        else if (gap > 0) break;
      end
      n_checks++; if (gap != 20) begin n_fail++; $display("FAIL octave_gap_len: got %0d want 20", gap); end
      n_checks++; if (buz_in_gap) begin n_fail++; $display("FAIL octave_gap_buzzer: got 1 want 0"); end
      lo = (buzzer === 1'b0) ? 1 : 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (buzzer === 1'b1) break;
        lo++;
      end
      n_checks++; if (lo != want) begin n_fail++; $display("FAIL octave_half: oct %0d got %0d want %0d", oct, lo, want); end
    end
  endtask

  task automatic test_gap_relatch();
    int gap, lo;
    drive(6, 1, 1'b1);
    repeat (60) @(negedge clk);
    drive(1, 1, 1'b1);
    gap = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); n_checks++;
      if ({buzzer, active, note_cur} !== {e_buz, e_act, e_note}) begin
        n_fail++; $display("FAIL relatch_model: got buz=%b act=%b note=%0d want buz=%b act=%b note=%0d", buzzer, active, note_cur, e_buz, e_act, e_note);
      end
      if (active === 1'b0) begin
        gap++;
        if (gap == 10) drive(3, 1, 1'b1);
      end else if (gap > 0) break;
    end
    n_checks++; if (gap != 20) begin n_fail++; $display("FAIL relatch_gap_len: got %0d want 20", gap); end
    n_checks++; if (note_cur !== 4'd3) begin n_fail++; $display("FAIL relatch_note: got %0d want 3", note_cur); end
    lo = (buzzer === 1'b0) ? 1 : 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (buzzer === 1'b1) break;
      lo++;
    end
    n_checks++; if (lo != 151) begin n_fail++; $display("FAIL relatch_half: got %0d want 151", lo); end
  endtask

  task automatic test_rest_enable();
    drive(0, 1, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++; if (active !== 1'b0 || buzzer !== 1'b0 || note_cur !== 4'd0) begin
      n_fail++; $display("FAIL rest_idle: act=%b buz=%b note=%0d want 0 0 0", active, buzzer, note_cur);
    end
    drive(1, 1, 1'b1);
    @(negedge clk);
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rest_resume_early: act=%b want 0", active); end
    @(negedge clk);
    n_checks++; if (active !== 1'b1 || note_cur !== 4'd1) begin
      n_fail++; $display("FAIL rest_resume_nogap: act=%b note=%0d want 1 1", active, note_cur);
    end
    drive(1, 1, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++; if (active !== 1'b0 || buzzer !== 1'b0 || note_cur !== 4'd0) begin
      n_fail++; $display("FAIL disable_idle: act=%b buz=%b note=%0d want 0 0 0", active, buzzer, note_cur);
    end
    drive(1, 1, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL enable_resume: act=%b want 1", active); end
  endtask

  task automatic test_rest9_oct3();
    int lo;
    bit dropped;
    drive(9, 1, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if (active !== 1'b0 || note_cur !== 4'd0) begin
      n_fail++; $display("FAIL note9_rest: act=%b note=%0d want 0 0", active, note_cur);
    end
    drive(1, 3, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL oct3_start: act=%b want 1", active); end
    lo = (buzzer === 1'b0) ? 1 : 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (buzzer === 1'b1) break;
      lo++;
    end
    n_checks++; if (lo != 190) begin n_fail++; $display("FAIL oct3_half: got %0d want 190", lo); end
    drive(1, 1, 1'b1);
    dropped = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (active !== 1'b1) dropped = 1'b1;
    end
    n_checks++; if (dropped) begin n_fail++; $display("FAIL oct3_to_mid_gap: got gap want none"); end
  endtask

  task automatic test_reset_midplay();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (buzzer !== 1'b0 || active !== 1'b0 || note_cur !== 4'd0) begin
      n_fail++; $display("FAIL midplay_reset: buz=%b act=%b note=%0d want 0 0 0", buzzer, active, note_cur);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL midplay_fresh_idle: act=%b want 0", active); end
    @(negedge clk);
    n_checks++; if (active !== 1'b1 || note_cur !== 4'd1) begin
      n_fail++; $display("FAIL midplay_restart: act=%b note=%0d want 1 1", active, note_cur);
    end
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 80; seg++) begin
      reset = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) drive(int'($urandom_range(8, 15)), int'($urandom_range(0, 3)), 1'b1);
      else drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom_range(0, 9) != 0);
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 400)) : int'($urandom_range(1, 40));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); n_checks++;
        if ({buzzer, active, note_cur} !== {e_buz, e_act, e_note}) begin
          n_fail++; $display("FAIL random_model: seg %0d got buz=%b act=%b note=%0d want buz=%b act=%b note=%0d", seg, buzzer, active, note_cur, e_buz, e_act, e_note);
        end
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_tone();
    test_octave();
    test_gap_relatch();
    test_rest_enable();
    test_rest9_oct3();
    test_reset_midplay();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
